sap_prog_loader: RTL and testbench

- Boot-time program loader for the 16-bit SAP computer.
- Accepts a byte stream (valid/ready) carrying a load frame, optionally zero-fills the RAM, then writes the framed words into RAM through a write port.
- Holds the CPU in reset for the whole session and releases it on success.
- Sits between the host byte link (UART RX or bench driver) and the sap RAM write port, muxed ahead of the CPU's own RAM write path.

---
 rtl/sap_pkg.sv | 22 ++
 rtl/sap_byte_assembler.sv | 36 +++
 rtl/sap_prog_loader.sv | 151 +++++++++++++++
 tb/tb_sap_prog_loader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP boot-time program loader: state encoding
// and field byte-count helpers.
package sap_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_HDR_A, S_HDR_N, S_DATA, S_DONE, S_ERR
    } load_state_t;

    function automatic int addr_bytes(input int addr_w);
        return (addr_w + 7) / 8;
    endfunction

    function automatic int word_bytes(input int data_w);
        return data_w / 8;
    endfunction

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;
    localparam int AB = addr_bytes(ADDR_W_DEF);
    localparam int WB = word_bytes(DATA_W_DEF);

endpackage

// File: rtl/sap_byte_assembler.sv
// Packs NBYTES stream bytes MSB-first into one word; word/word_valid are
// combinational so the caller sees the full value on the last byte's cycle.
module sap_byte_assembler #(
    parameter int NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [7:0]            byte_in,
    output logic [NBYTES*8-1:0]   word,
    output logic                  word_valid
);
    localparam int CW = $clog2(NBYTES + 1);

    logic [NBYTES*8-1:0] sh;
    logic [CW-1:0]       cnt;
    logic [NBYTES*8+7:0] cat;

    assign cat        = {sh, byte_in};
    assign word       = cat[NBYTES*8-1:0];
    assign word_valid = en && (cnt == CW'(NBYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh  <= '0;
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            sh  <= word;
            cnt <= word_valid ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sap_prog_loader.sv
// Boot loader: optional RAM zero-fill, then a framed byte stream
// (start, count, words) written into RAM while the CPU is held in reset.
module sap_prog_loader
    import sap_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter bit CLEAR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int NAB   = addr_bytes(ADDR_W);
    localparam int NWB   = word_bytes(DATA_W);
    localparam int NW    = (NAB + 1) * 8;
    localparam int DEPTH = 2 ** ADDR_W;

    load_state_t       state;
    logic [ADDR_W-1:0] start, ptr;
    logic [ADDR_W:0]   remaining;

    logic              take, en_a, en_n, en_d, clr_asm;
    logic [NAB*8-1:0]  a_word;
    logic [NW-1:0]     n_word;
    logic [DATA_W-1:0] d_word;
    logic              a_vld, n_vld, d_vld;
    logic [NW:0]       end_sum;
    logic              too_big;

    assign take    = rx_valid && rx_ready;
    assign en_a    = take && (state == S_HDR_A);
    assign en_n    = take && (state == S_HDR_N);
    assign en_d    = take && (state == S_DATA);
    assign clr_asm = (state == S_IDLE) && load_req;

    sap_byte_assembler #(.NBYTES(NAB)) u_addr (
        .clk(clk), .rst(rst), .clr(clr_asm), .en(en_a), .byte_in(rx_data),
        .word(a_word), .word_valid(a_vld));

    sap_byte_assembler #(.NBYTES(NAB + 1)) u_cnt (
        .clk(clk), .rst(rst), .clr(clr_asm), .en(en_n), .byte_in(rx_data),
        .word(n_word), .word_valid(n_vld));

    sap_byte_assembler #(.NBYTES(NWB)) u_data (
        .clk(clk), .rst(rst), .clr(clr_asm), .en(en_d), .byte_in(rx_data),
        .word(d_word), .word_valid(d_vld));

    // Widened so start+N cannot wrap and the range check stays exact.
    assign end_sum = (NW+1)'(start) + (NW+1)'(n_word);
    assign too_big = end_sum > (NW+1)'(DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cpu_rst   <= 1'b1;
            rx_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            start     <= '0;
            ptr       <= '0;
            remaining <= '0;
        end else begin
            case (state)
                S_IDLE: if (load_req) begin
                    busy    <= 1'b1;
                    cpu_rst <= 1'b1;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    if (CLEAR_EN) begin
                        state     <= S_CLEAR;
                        mem_we    <= 1'b1;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                    end else begin
                        state    <= S_HDR_A;
                        rx_ready <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (&mem_addr) begin
                        mem_we   <= 1'b0;
                        rx_ready <= 1'b1;
                        state    <= S_HDR_A;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                S_HDR_A: if (a_vld) begin
                    start <= a_word[ADDR_W-1:0];
                    state <= S_HDR_N;
                end
                S_HDR_N: if (n_vld) begin
                    if (too_big) begin
                        rx_ready <= 1'b0;
                        state    <= S_ERR;
                    end else if (n_word == '0) begin
                        rx_ready <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        ptr       <= start;
                        remaining <= n_word[ADDR_W:0];
                        state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    // mem_we high marks the write cycle that follows the last byte of a word.
                    if (mem_we) begin
                        mem_we    <= 1'b0;
                        ptr       <= ptr + ADDR_W'(1);
                        remaining <= remaining - (ADDR_W+1)'(1);
                        if (remaining == (ADDR_W+1)'(1)) state <= S_DONE;
                        else rx_ready <= 1'b1;
                    end else if (d_vld) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr;
                        mem_wdata <= d_word;
                        rx_ready  <= 1'b0;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    cpu_rst <= 1'b0;
                    state   <= S_IDLE;
                end
                S_ERR: begin
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_prog_loader.sv
// Directed bench for sap_prog_loader: clear pass, framed loads, range error,
// stalls, ignored mid-session requests and asynchronous reset abort.
module tb_sap_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_req = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, mem_we, cpu_rst, busy, done, err;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;
    logic [15:0] ram [0:255];

    always #5 clk = ~clk;

    sap_prog_loader #(.DATA_W(16), .ADDR_W(8), .CLEAR_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
        .busy(busy), .done(done), .err(err));

    always @(posedge clk) if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        we_cnt = we_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_ram(input logic [15:0] v);
        for (int i = 0; i < 256; i++) ram[i] = v;
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("rx_ready_timeout", rx_ready, 1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_load();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("busy_timeout", busy, 0);
    endtask

    task automatic start_session();
        fill_ram(16'hFFFF);
        we_cnt = 0;
        pulse_load();
    endtask

    int nz;

    initial begin
        // Reset state
        #12;
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_outs", {busy, done, err}, 0);
        chk("rst_addr_data", {mem_addr, mem_wdata}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_hold", {cpu_rst, rx_ready, mem_we, done, err, busy}, 6'b100000);

        // Session 1: clear, then mem[0]=0003
        start_session();
        chk("s1_busy", busy, 1);
        send(8'h00, 0);
        chk("s1_clear_cnt", we_cnt, 256);
        nz = 0;
        for (int i = 0; i < 256; i++) if (ram[i] != 16'h0) nz++;
        chk("s1_clear_zero", nz, 0);
        send(8'h00, 0); send(8'h01, 0);
        send(8'h00, 0); send(8'h03, 0);
        chk("s1_write_cycle", {mem_we, rx_ready, done}, 3'b100);
        chk("s1_write_val", {mem_addr, mem_wdata}, {8'h00, 16'h0003});
        @(negedge clk);
        chk("s1_pre_done", {done, cpu_rst, busy}, 3'b011);
        @(negedge clk);
        chk("s1_done", {done, cpu_rst, busy, err}, 4'b1000);
        chk("s1_mem0", ram[0], 16'h0003);
        chk("s1_we_total", we_cnt, 257);

        // Session 2: three words at 0x0A
        start_session();
        chk("s2_reassert", {cpu_rst, done}, 2'b10);
        send(8'h0A, 0); send(8'h00, 0); send(8'h03, 0);
        send(8'h0B, 0); send(8'h00, 0);
        send(8'h02, 0); send(8'h00, 0);
        send(8'h08, 0); send(8'h0A, 0);
        wait_idle();
        chk("s2_mem10", ram[10], 16'h0B00);
        chk("s2_mem11", ram[11], 16'h0200);
        chk("s2_mem12", ram[12], 16'h080A);
        chk("s2_neighbours", {ram[9], ram[13], ram[0]}, 0);
        chk("s2_we_total", we_cnt, 259);
        chk("s2_flags", {done, cpu_rst, err}, 3'b100);

        // Session 3: FF + 2 overflows DEPTH
        start_session();
        send(8'hFF, 0); send(8'h00, 0); send(8'h02, 0);
        wait_idle();
        chk("s3_err", {err, done, cpu_rst}, 3'b101);
        chk("s3_no_data", we_cnt, 256);
        start_session();
        chk("s4_err_clr", err, 0);

        // Session 4: FF + 1 is the last legal slot
        send(8'hFF, 0); send(8'h00, 0); send(8'h01, 0);
        send(8'hAB, 0); send(8'hCD, 0);
        wait_idle();
        chk("s4_mem255", ram[255], 16'hABCD);
        chk("s4_flags", {done, err, cpu_rst, we_cnt[15:0]}, {3'b100, 16'd257});

        // Session 5: N=0 finishes with only the clear writes
        start_session();
        send(8'h07, 0); send(8'h00, 0); send(8'h00, 0);
        wait_idle();
        chk("s5_n0", {done, err, we_cnt[15:0]}, {2'b10, 16'd256});

        // Session 6: stalls plus an ignored load_req mid-stream
        start_session();
        send(8'h0A, 2); send(8'h00, 0); send(8'h03, 1);
        send(8'h0B, $urandom_range(0, 4)); send(8'h00, $urandom_range(0, 4));
        pulse_load();
        send(8'h02, $urandom_range(0, 4)); send(8'h00, $urandom_range(0, 4));
        send(8'h08, 3); send(8'h0A, 5);
        wait_idle();
        chk("s6_mem", {ram[10], ram[11], ram[12]}, {16'h0B00, 16'h0200, 16'h080A});
        chk("s6_we_total", we_cnt, 259);
        chk("s6_flags", {done, err, busy}, 3'b100);

        // Session 7: asynchronous reset in the middle of DATA
        start_session();
        send(8'h0A, 0); send(8'h00, 0); send(8'h03, 0);
        send(8'h55, 0); send(8'h66, 0); send(8'h77, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("s7_abort", {cpu_rst, rx_ready, mem_we, busy, done, err}, 6'b100000);
        chk("s7_abort_bus", {mem_addr, mem_wdata}, 0);
        chk("s7_partial", ram[10], 16'h5566);
        @(negedge clk);
        rst = 1'b0;
        start_session();
        send(8'h20, 0); send(8'h00, 0); send(8'h02, 0);
        send(8'h11, 0); send(8'h11, 0);
        send(8'h22, 0); send(8'h22, 0);
        wait_idle();
        chk("s7_mem", {ram[32], ram[33], ram[10]}, {16'h1111, 16'h2222, 16'h0000});
        chk("s7_flags", {done, err, cpu_rst}, 3'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
